// File: rtl/mceliece_stream_encrypt.sv
// mceliece_stream_encrypt: streaming GF(2) encryption, cipher = (message x G') ^ error.
// Key columns are reduced as they arrive, so no key store is held.
module mceliece_stream_encrypt #(
  parameter int Q = 5,
  parameter int T = 2,
  parameter int P = 4,
  localparam int NM = Q * Q,
  localparam int K = NM + 2 * T * Q,
  localparam int CW = $clog2(K + P)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic [NM-1:0] message_i,
  input  logic [K-1:0]  error_i,
  input  logic          key_valid_i,
  output logic          key_ready_o,
  input  logic [P*NM-1:0] key_cols_i,
  output logic [K-1:0]  cipher_o,
  output logic          cipher_valid_o,
  input  logic          cipher_ack_i,
  output logic          busy_o
);
  typedef enum logic [1:0] {IDLE, LOAD, ADD, DONE} state_t;
  state_t state_q;
  logic [CW-1:0] col_q, idx;
  logic [NM-1:0] msg_q;
  logic [K-1:0] err_q, cw_q, cw_d, cipher_q;
  logic valid_q, ready_q, busy_q, accept, beat;
  assign accept = start_i && !abort_i && (state_q == IDLE || (state_q == DONE && cipher_ack_i));
  assign beat = key_valid_i && ready_q;
  // Columns past K on the final beat fall outside the codeword and are dropped.
  always_comb begin
    cw_d = cw_q;
    idx = '0;
    for (int i = 0; i < P; i++) begin
      idx = col_q + CW'(i);
      if (idx < CW'(K)) cw_d[idx] = ^(key_cols_i[i*NM +: NM] & msg_q);
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      col_q <= '0;
      msg_q <= '0;
      err_q <= '0;
      cw_q <= '0;
      cipher_q <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
      busy_q <= 1'b0;
    end else if (abort_i && state_q != IDLE) begin
      state_q <= IDLE;
      cipher_q <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
      busy_q <= 1'b0;
    end else if (accept) begin
      state_q <= LOAD;
      msg_q <= message_i;
      err_q <= error_i;
      cw_q <= '0;
      col_q <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      busy_q <= 1'b1;
    end else begin
      case (state_q)
        LOAD: if (beat) begin
          cw_q <= cw_d;
          col_q <= col_q + CW'(P);
          if (col_q + CW'(P) >= CW'(K)) begin
            state_q <= ADD;
            ready_q <= 1'b0;
          end
        end
        ADD: begin
          cipher_q <= cw_q ^ err_q;
          valid_q <= 1'b1;
          state_q <= DONE;
        end
        DONE: if (cipher_ack_i) begin
          valid_q <= 1'b0;
          busy_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign cipher_o = cipher_q;
  assign cipher_valid_o = valid_q;
  assign key_ready_o = ready_q;
  assign busy_o = busy_q;
endmodule
